sync_edge_detector3: RTL and testbench



---
 rtl/sync_edge_detector3_pkg.sv | 9 +
 rtl/sync_edge_detector3_sync_ff_chain.sv | 30 +++
 rtl/sync_edge_detector3.sv | 69 ++++++
 tb/tb_sync_edge_detector3.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sync_edge_detector3_pkg.sv
// Shared helpers for the bus change detector.
package sync_edge_detector3_pkg;

  // Only no synchroniser, or a two- or three-flop synchroniser, is supported.
  function automatic bit sync_stages_legal(input int n);
    return (n == 0) || (n == 2) || (n == 3);
  endfunction

endpackage

// File: rtl/sync_edge_detector3_sync_ff_chain.sv
// Multi-bit flip-flop synchroniser chain with async reset to a fixed value.
module sync_ff_chain #(
  parameter int               WIDTH       = 3,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  // Shift the bus one stage further down the chain every edge.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  // Chain registers; reset loads every stage so no stale value leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= {STAGES{RESET_VALUE}};
    else     stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_edge_detector3.sv
// Per-cycle change detector: flags any difference between the sampled bus
// and its value on the previous edge, plus per-bit rise/fall.
module sync_edge_detector3
  import sync_edge_detector3_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic             changed,
  output logic             changed_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             chg_dly_q, chg_dly_d;

  generate
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
      $error("sync_edge_detector3: SYNC_STAGES must be 0, 2 or 3");
    end
    if (SYNC_STAGES == 0) begin : g_direct
      // Bus is already in the clk domain; detect with zero latency.
      assign s = in;
    end else begin : g_sync
      sync_ff_chain #(
        .WIDTH      (WIDTH),
        .STAGES     (SYNC_STAGES),
        .RESET_VALUE(RESET_VALUE)
      ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (s)
      );
    end
  endgenerate

  // Detection terms are purely combinational against the history register.
  always_comb begin
    prev_d    = s;
    changed   = |(s ^ prev_q);
    rise      = s & ~prev_q;
    fall      = ~s & prev_q;
    chg_dly_d = changed;
  end

  // History and delayed-pulse registers; reset discards history at once so
  // leaving reset with s != RESET_VALUE reads as a fresh state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= RESET_VALUE;
      chg_dly_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      chg_dly_q <= chg_dly_d;
    end
  end

  assign prev      = prev_q;
  assign changed_q = chg_dly_q;

endmodule

// File: tb/tb_sync_edge_detector3.sv
// Scoreboard bench: three detector variants fed from one random bus.
module tb_sync_edge_detector3;

  localparam int W = 3;
  localparam logic [W-1:0] RV0 = 3'b000;
  localparam logic [W-1:0] RV3 = 3'b101;

  typedef struct packed {
    logic         ch;
    logic         chq;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] prev;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in  = '0;

  logic         ch0, chq0, ch2, chq2, ch3, chq3;
  logic [W-1:0] ri0, fa0, pv0, ri2, fa2, pv2, ri3, fa3, pv3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] vin_h[$];
  bit           vrst_h[$];
  exp_t q0[$], q2[$], q3[$];

  always #5 clk = ~clk;

  sync_edge_detector3 #(.WIDTH(W), .SYNC_STAGES(0), .RESET_VALUE(RV0)) d0 (
    .clk(clk), .rst(rst), .in(in), .changed(ch0), .changed_q(chq0),
    .rise(ri0), .fall(fa0), .prev(pv0));
  sync_edge_detector3 #(.WIDTH(W), .SYNC_STAGES(2), .RESET_VALUE(RV0)) d2 (
    .clk(clk), .rst(rst), .in(in), .changed(ch2), .changed_q(chq2),
    .rise(ri2), .fall(fa2), .prev(pv2));
  sync_edge_detector3 #(.WIDTH(W), .SYNC_STAGES(3), .RESET_VALUE(RV3)) d3 (
    .clk(clk), .rst(rst), .in(in), .changed(ch3), .changed_q(chq3),
    .rise(ri3), .fall(fa3), .prev(pv3));

  // Reference model over cycle history. Cycle k is the interval after edge k.
  // Any register reads RESET_VALUE in cycle k if reset was high in cycle k or
  // k-1 (an edge taken under reset). Cycles before the bench start count as reset.
  function automatic bit rst_at(input int k);
    return (k < 0) ? 1'b1 : vrst_h[k];
  endfunction

  // Sampled bus: input from n cycles ago, unless a reset fell inside the window.
  function automatic logic [W-1:0] m_s(input int k, input int n, input logic [W-1:0] r);
    if (n == 0) return vin_h[k];
    for (int j = k - n; j <= k; j++) if (rst_at(j)) return r;
    return vin_h[k-n];
  endfunction

  function automatic logic [W-1:0] m_prev(input int k, input int n, input logic [W-1:0] r);
    if (rst_at(k) || rst_at(k-1)) return r;
    return m_s(k-1, n, r);
  endfunction

  function automatic logic m_ch(input int k, input int n, input logic [W-1:0] r);
    return m_s(k, n, r) != m_prev(k, n, r);
  endfunction

  function automatic exp_t model(input int k, input int n, input logic [W-1:0] r);
    exp_t e;
    logic [W-1:0] s, p;
    s      = m_s(k, n, r);
    p      = m_prev(k, n, r);
    e.ch   = (s != p);
    e.rise = s & ~p;
    e.fall = ~s & p;
    e.prev = p;
    e.chq  = (rst_at(k) || rst_at(k-1)) ? 1'b0 : m_ch(k-1, n, r);
    return e;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what each
  // variant must show during that cycle.
  task automatic drv(input logic [W-1:0] v, input bit r);
    @(posedge clk);
    #1;
    in  = v;
    rst = r;
    vin_h.push_back(v);
    vrst_h.push_back(r);
    q0.push_back(model(cyc, 0, RV0));
    q2.push_back(model(cyc, 2, RV0));
    q3.push_back(model(cyc, 3, RV3));
    cyc++;
  endtask

  task automatic cmp(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b", name, k, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k, input exp_t e,
                           input logic ch, input logic chq, input logic [W-1:0] ri,
                           input logic [W-1:0] fa, input logic [W-1:0] pv);
    cmp({tag, ".changed"},   k, {2'b00, ch},  {2'b00, e.ch});
    cmp({tag, ".changed_q"}, k, {2'b00, chq}, {2'b00, e.chq});
    cmp({tag, ".rise"},      k, ri, e.rise);
    cmp({tag, ".fall"},      k, fa, e.fall);
    cmp({tag, ".prev"},      k, pv, e.prev);
  endtask

  // Monitor: mid-cycle, pop and compare whatever the stimulus queued.
  int mon_k = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        check_all("s0", mon_k, q0.pop_front(), ch0, chq0, ri0, fa0, pv0);
        check_all("s2", mon_k, q2.pop_front(), ch2, chq2, ri2, fa2, pv2);
        check_all("s3", mon_k, q3.pop_front(), ch3, chq3, ri3, fa3, pv3);
        mon_k++;
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    bit r;
    // Directed: reset, idle, single step, multi-bit step, toggling, mid-run reset, 0->6.
    repeat (2) drv(3'd0, 1'b1);
    repeat (5) drv(3'd0, 1'b0);
    repeat (3) drv(3'd1, 1'b0);
    repeat (2) drv(3'b101, 1'b0);
    repeat (2) drv(3'b010, 1'b0);
    for (int i = 0; i < 8; i++) drv((i % 2) ? 3'd2 : 3'd1, 1'b0);
    repeat (3) drv(3'd2, 1'b0);
    repeat (2) drv(3'd1, 1'b0);
    repeat (2) drv(3'd1, 1'b1);
    repeat (3) drv(3'd1, 1'b0);
    repeat (4) drv(3'd0, 1'b0);
    repeat (6) drv(3'd6, 1'b0);
    drv(3'd2, 1'b1);
    repeat (4) drv(3'd2, 1'b0);
    // Random: mostly holds with occasional steps and rare resets.
    v = 3'd6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) v = W'($urandom);
      r = ($urandom_range(0, 29) == 0);
      drv(v, r);
    end
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q0.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
